// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake game blocks: grid defaults, FSM states,
// cell-index width helper and the Galois LFSR tap table.
package snake_pkg;

  localparam int GRID_W_DEF = 32;
  localparam int GRID_H_DEF = 24;
  localparam int CELL_W_DEF = 20;
  localparam int CELL_H_DEF = 20;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAW  = 3'd1,
    QUERY = 3'd2,
    WAIT  = 3'd3,
    SCAN  = 3'd4,
    DONE  = 3'd5
  } state_t;

  // Bits needed to index n cells along one axis (never less than one).
  function automatic int cell_bits(input int n);
    if (n <= 2) begin
      return 1;
    end else begin
      return $clog2(n);
    end
  endfunction

  // Right-shifting Galois feedback masks giving maximal-length sequences.
  function automatic logic [63:0] lfsr_taps(input int w);
    case (w)
      8:       return 64'h0000_0000_0000_00B8;
      10:      return 64'h0000_0000_0000_0240;
      12:      return 64'h0000_0000_0000_0E08;
      16:      return 64'h0000_0000_0000_B400;
      20:      return 64'h0000_0000_0009_0000;
      24:      return 64'h0000_0000_00E1_0000;
      32:      return 64'h0000_0000_8020_0003;
      default: return 64'h0000_0000_0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/lfsr_gen.sv
// Free-running Galois LFSR; a zero seed is replaced by 1 so the register never locks up.
module lfsr_gen #(
  parameter int                WIDTH = 16,
  parameter logic [WIDTH-1:0]  TAPS  = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED  = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] INIT = (SEED == {WIDTH{1'b0}}) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  // Shift right every clock, folding the taps in when a one falls out.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= INIT;
    end else begin
      q <= {1'b0, q[WIDTH-1:1]} ^ (q[0] ? TAPS : {WIDTH{1'b0}});
    end
  end

endmodule

// File: rtl/food_pos_gen.sv
// Picks a pseudo-random free grid cell for the next food item: LFSR draws checked against
// the snake-body store, with a linear-scan fallback. FPG_BORDER_EXCL_EN keeps food off the border ring.
module food_pos_gen
  import snake_pkg::*;
#(
  parameter int                GRID_W    = GRID_W_DEF,
  parameter int                GRID_H    = GRID_H_DEF,
  parameter int                CELL_W    = CELL_W_DEF,
  parameter int                CELL_H    = CELL_H_DEF,
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED      = 16'hACE1,
  parameter int                MAX_TRIES = 15
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  output logic                         busy,
  output logic                         valid,
  output logic                         fail,
  output logic [cell_bits(GRID_W)-1:0] cell_x,
  output logic [cell_bits(GRID_H)-1:0] cell_y,
  output logic [9:0]                   randx,
  output logic [8:0]                   randy,
  output logic [cell_bits(GRID_W)-1:0] occ_qx,
  output logic [cell_bits(GRID_H)-1:0] occ_qy,
  output logic                         occ_qvld,
  input  logic                         occ_hit
);

  localparam int XW = cell_bits(GRID_W);
  localparam int YW = cell_bits(GRID_H);
  localparam int TW = $clog2(MAX_TRIES + 1);
`ifdef FPG_BORDER_EXCL_EN
  localparam int NCELL = (GRID_W - 2) * (GRID_H - 2);
`else
  localparam int NCELL = GRID_W * GRID_H;
`endif
  localparam int HW = $clog2(NCELL + 1);

  localparam logic [XW-1:0] X_MAX    = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_MAX    = YW'(GRID_H - 1);
  localparam logic [TW-1:0] TRY_LAST = TW'(MAX_TRIES - 1);
  localparam logic [HW-1:0] HIT_LAST = HW'(NCELL - 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic [XW-1:0]     draw_x;
  logic [YW-1:0]     draw_y;
  state_t            state;
  logic [TW-1:0]     tries;
  logic [HW-1:0]     hit_cnt;
  logic              scanning;
  logic [XW-1:0]     scan_x;
  logic [YW-1:0]     scan_y;

  lfsr_gen #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_W'(lfsr_taps(LFSR_W))),
    .SEED  (SEED)
  ) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign draw_x = lfsr_q[XW-1:0];
  assign draw_y = lfsr_q[XW+YW-1:XW];

  if (LFSR_W > XW + YW) begin : g_spare
    logic unused_lfsr_hi;
    assign unused_lfsr_hi = ^lfsr_q[LFSR_W-1:XW+YW];
  end

  function automatic logic eligible(input logic [XW-1:0] x, input logic [YW-1:0] y);
`ifdef FPG_BORDER_EXCL_EN
    return (x != XW'(0)) && (x < X_MAX) && (y != YW'(0)) && (y < Y_MAX);
`else
    return (x <= X_MAX) && (y <= Y_MAX);
`endif
  endfunction

  // Row-major successor with wrap from the last cell back to (0,0); returns {y, x}.
  function automatic logic [XW+YW-1:0] next_cell(input logic [XW-1:0] x, input logic [YW-1:0] y);
    logic [XW-1:0] nx;
    logic [YW-1:0] ny;
    if (x >= X_MAX) begin
      nx = XW'(0);
      if (y >= Y_MAX) begin
        ny = YW'(0);
      end else begin
        ny = y + YW'(1);
      end
    end else begin
      nx = x + XW'(1);
      ny = y;
    end
    return {ny, nx};
  endfunction

  // Control FSM; every output is registered on the transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      tries    <= TW'(0);
      hit_cnt  <= HW'(0);
      scanning <= 1'b0;
      scan_x   <= XW'(0);
      scan_y   <= YW'(0);
      busy     <= 1'b0;
      valid    <= 1'b0;
      fail     <= 1'b0;
      cell_x   <= XW'(0);
      cell_y   <= YW'(0);
      randx    <= 10'd0;
      randy    <= 9'd0;
      occ_qx   <= XW'(0);
      occ_qy   <= YW'(0);
      occ_qvld <= 1'b0;
    end else begin
      valid    <= 1'b0;
      occ_qvld <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            busy  <= 1'b1;
            state <= DRAW;
          end else begin
            state <= IDLE;
          end
        end
        DRAW: begin
          if (eligible(draw_x, draw_y)) begin
            occ_qvld <= 1'b1;
            occ_qx   <= draw_x;
            occ_qy   <= draw_y;
            state    <= QUERY;
          end else if (tries == TRY_LAST) begin
            tries    <= tries + TW'(1);
            scanning <= 1'b1;
            scan_x   <= (draw_x > X_MAX) ? X_MAX : draw_x;
            scan_y   <= (draw_y > Y_MAX) ? Y_MAX : draw_y;
            state    <= SCAN;
          end else begin
            tries <= tries + TW'(1);
            state <= DRAW;
          end
        end
        QUERY: begin
          state <= WAIT;
        end
        WAIT: begin
          if (!occ_hit) begin
            valid  <= 1'b1;
            fail   <= 1'b0;
            cell_x <= occ_qx;
            cell_y <= occ_qy;
            randx  <= 10'(32'(occ_qx) * 32'(CELL_W));
            randy  <= 9'(32'(occ_qy) * 32'(CELL_H));
            state  <= DONE;
          end else if (scanning && (hit_cnt == HIT_LAST)) begin
            valid  <= 1'b1;
            fail   <= 1'b1;
            cell_x <= XW'(0);
            cell_y <= YW'(0);
            randx  <= 10'd0;
            randy  <= 9'd0;
            state  <= DONE;
          end else if (scanning) begin
            hit_cnt          <= hit_cnt + HW'(1);
            {scan_y, scan_x} <= next_cell(occ_qx, occ_qy);
            state            <= SCAN;
          end else if (tries == TRY_LAST) begin
            tries    <= tries + TW'(1);
            scanning <= 1'b1;
            scan_x   <= occ_qx;
            scan_y   <= occ_qy;
            state    <= SCAN;
          end else begin
            tries <= tries + TW'(1);
            state <= DRAW;
          end
        end
        SCAN: begin
          // Ineligible cells are stepped over without spending a query.
          if (eligible(scan_x, scan_y)) begin
            occ_qvld <= 1'b1;
            occ_qx   <= scan_x;
            occ_qy   <= scan_y;
            state    <= QUERY;
          end else begin
            {scan_y, scan_x} <= next_cell(scan_x, scan_y);
            state            <= SCAN;
          end
        end
        DONE: begin
          tries    <= TW'(0);
          hit_cnt  <= HW'(0);
          scanning <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_food_pos_gen.sv
// Self-checking bench for food_pos_gen (default parameters, 32x24 grid of 20x20 cells),
// with an occupancy responder and an independent LFSR/draw model.
module tb_food_pos_gen;

  logic       clk = 1'b0;
  logic       rst, req, occ_hit;
  logic       busy, valid, fail, occ_qvld;
  logic [4:0] cell_x, cell_y, occ_qx, occ_qy;
  logic [9:0] randx;
  logic [8:0] randy;

`ifdef FPG_BORDER_EXCL_EN
  localparam bit BORDER = 1'b1;
  localparam int ELIG   = 660;
`else
  localparam bit BORDER = 1'b0;
  localparam int ELIG   = 768;
`endif

  food_pos_gen dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .valid(valid), .fail(fail),
    .cell_x(cell_x), .cell_y(cell_y), .randx(randx), .randy(randy),
    .occ_qx(occ_qx), .occ_qy(occ_qy), .occ_qvld(occ_qvld), .occ_hit(occ_hit)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int qcnt = 0, vcnt = 0, first_q_cyc = -1, v_cyc = -1, border_q = 0;
  int mode = 0, hit_k = 0, tx = 0, ty = 0;
  bit hit_next = 1'b0;
  logic [15:0] m_lfsr;

  typedef struct {
    int tx;
    int ty;
    int px;
    int py;
  } scan_vec_t;
  scan_vec_t vecs[4];

  function automatic logic [15:0] step(input logic [15:0] v);
    return {1'b0, v[15:1]} ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic bit elig(input int x, input int y);
    if (BORDER) return (x > 0) && (x < 31) && (y > 0) && (y < 23);
    else        return (x < 32) && (y < 24);
  endfunction

  // Occupancy policy: 0 empty, 1 first hit_k queries hit, 2 all but (tx,ty), 3 full.
  function automatic bit hit_policy(input int q, input int x, input int y);
    case (mode)
      1:       return q <= hit_k;
      2:       return !((x == tx) && (y == ty));
      3:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Expected result and query count given the LFSR value seen in the first DRAW cycle.
  task automatic predict(input logic [15:0] s0, output int ex, output int ey,
                         output int eq, output int ef);
    logic [15:0] v = s0;
    int tries = 0, q = 0, lx = 0, ly = 0, n = 0, sx, sy, cx, cy;
    bit done = 1'b0, scan = 1'b0;
    ex = 0; ey = 0; ef = 0;
    for (int g = 0; g < 64 && !done && !scan; g++) begin
      cx = int'(v[4:0]); cy = int'(v[9:5]); lx = cx; ly = cy;
      if (!elig(cx, cy)) begin
        tries++; v = step(v);
      end else begin
        q++;
        if (!hit_policy(q, cx, cy)) begin
          ex = cx; ey = cy; done = 1'b1;
        end else begin
          tries++; v = step(step(step(v)));
        end
      end
      if (!done && tries == 15) scan = 1'b1;
    end
    sx = lx; sy = (ly > 23) ? 23 : ly;
    for (int i = 0; i < 768 && scan && !done; i++) begin
      if (elig(sx, sy)) begin
        q++;
        if (!hit_policy(q, sx, sy)) begin
          ex = sx; ey = sy; done = 1'b1;
        end else begin
          n++;
          if (n == ELIG) begin ex = 0; ey = 0; ef = 1; done = 1'b1; end
        end
      end
      if (sx == 31) begin sx = 0; sy = (sy == 23) ? 0 : sy + 1; end
      else sx = sx + 1;
    end
    eq = q;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step_cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(output logic [15:0] s0, output int c0, output int vbase);
    req = 1'b1;
    s0 = step(m_lfsr);
    c0 = cyc;
    qcnt = 0;
    first_q_cyc = -1;
    border_q = 0;
    vbase = vcnt;
    step_cyc();
    req = 1'b0;
  endtask

  task automatic wait_valid(input int vbase, input int budget, input string name);
    int n = 0;
    while (vcnt == vbase && n < budget) begin
      step_cyc();
      n++;
    end
    if (vcnt == vbase) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no valid within %0d cycles", name, budget);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    m_lfsr <= rst ? 16'hACE1 : step(m_lfsr);
  end

  // Observe queries and results; decide the occupancy answer for each query.
  initial forever begin
    @(negedge clk);
    if (occ_qvld === 1'b1) begin
      qcnt++;
      if (first_q_cyc < 0) first_q_cyc = cyc;
      if (occ_qx == 5'd0 || occ_qx == 5'd31 || occ_qy == 5'd0 || occ_qy == 5'd23) border_q++;
      hit_next = hit_policy(qcnt, int'(occ_qx), int'(occ_qy));
    end
    if (valid === 1'b1) begin
      vcnt++;
      v_cyc = cyc;
    end
  end

  // occ_hit is presented during the cycle after the query strobe.
  initial begin
    occ_hit = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      occ_hit  = hit_next;
      hit_next = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] s0, nv;
    int c0, vb, ex, ey, eq, ef, g;

    vecs[0] = BORDER ? '{30, 22, 600, 440} : '{31, 23, 620, 460};
    vecs[1] = '{5, 7, 100, 140};
    vecs[2] = '{17, 12, 340, 240};
    vecs[3] = '{1, 1, 20, 20};

    rst = 1'b1; req = 1'b0;
    repeat (3) @(posedge clk);
    step_cyc();
    check("rst_valid", valid, 0);
    check("rst_busy", busy, 0);
    check("rst_randx", randx, 0);
    check("rst_randy", randy, 0);
    check("rst_qvld", occ_qvld, 0);
    check("rst_lfsr", dut.u_lfsr.q, 16'hACE1);
    rst = 1'b0;
    step_cyc();

    // Empty board, best-case latency: request when the next draw lands in range.
    mode = 0;
    for (int r = 0; r < 3; r++) begin
      g = 0;
      nv = step(m_lfsr);
      while (!elig(int'(nv[4:0]), int'(nv[9:5])) && g < 50) begin
        step_cyc(); g++; nv = step(m_lfsr);
      end
      do_req(s0, c0, vb);
      predict(s0, ex, ey, eq, ef);
      wait_valid(vb, 40, "empty_timeout");
      check("empty_qvld_lat", first_q_cyc - c0, 2);
      check("empty_valid_lat", v_cyc - c0, 4);
      check("empty_fail", fail, 0);
      check("empty_x", cell_x, ex);
      check("empty_y", cell_y, ey);
      check("empty_randx", randx, int'(cell_x) * 20);
      check("empty_randy", randy, int'(cell_y) * 20);
      step_cyc();
      check("empty_idle_busy", busy, 0);
      check("empty_valid_pulse", valid, 0);
      repeat (r + 2) step_cyc();
    end

    // Rejection: two occupied answers, then free.
    mode = 1; hit_k = 2;
    do_req(s0, c0, vb);
    predict(s0, ex, ey, eq, ef);
    wait_valid(vb, 200, "rej_timeout");
    check("rej_queries", qcnt, 3);
    check("rej_x", cell_x, ex);
    check("rej_y", cell_y, ey);
    check("rej_fail", fail, 0);
    repeat (3) step_cyc();

    // Fallback scan: everything occupied except one target cell.
    mode = 2;
    for (int i = 0; i < 4; i++) begin
      tx = vecs[i].tx; ty = vecs[i].ty;
      do_req(s0, c0, vb);
      predict(s0, ex, ey, eq, ef);
      wait_valid(vb, 3000, "scan_timeout");
      check("scan_x", cell_x, vecs[i].tx);
      check("scan_y", cell_y, vecs[i].ty);
      check("scan_randx", randx, vecs[i].px);
      check("scan_randy", randy, vecs[i].py);
      check("scan_fail", fail, 0);
      check("scan_queries", qcnt, eq);
      repeat (2) step_cyc();
    end

    // Full board: every query hits.
    mode = 3;
    do_req(s0, c0, vb);
    predict(s0, ex, ey, eq, ef);
    wait_valid(vb, 3000, "full_timeout");
    check("full_fail", fail, 1);
    check("full_x", cell_x, 0);
    check("full_y", cell_y, 0);
    check("full_randx", randx, 0);
    check("full_randy", randy, 0);
    check("full_queries", qcnt, eq);
    check("full_scan_min", (qcnt >= ELIG) ? 1 : 0, 1);
`ifdef FPG_BORDER_EXCL_EN
    check("full_border_queries", border_q, 0);
`endif
    repeat (2) step_cyc();

    // Abort: reset while waiting for the occupancy answer.
    mode = 0;
    do_req(s0, c0, vb);
    g = 0;
    while (qcnt == 0 && g < 40) begin step_cyc(); g++; end
    check("abort_reached_query", (qcnt > 0) ? 1 : 0, 1);
    step_cyc();
    rst = 1'b1;
    step_cyc();
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    check("abort_lfsr", dut.u_lfsr.q, 16'hACE1);
    rst = 1'b0;
    repeat (10) step_cyc();
    check("abort_no_valid", vcnt - vb, 0);

    // Requests while busy are dropped.
    do_req(s0, c0, vb);
    step_cyc();
    req = 1'b1;
    step_cyc();
    req = 1'b0;
    repeat (60) step_cyc();
    check("busy_req_valids", vcnt - vb, 1);
    check("busy_req_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
